// File: rtl/signed_acc_stage_if.sv
// Handshake/bus bundle for signed_acc_stage: operand stream in, sequence result out.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid && ready; the
// sender holds its payload stable while valid && !ready.
interface signed_acc_stage_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sub;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_ovf;
  logic [7:0]       out_count;

  modport master (
    output in_valid, in_data, in_sub, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_count
  );

  modport slave (
    input  in_valid, in_data, in_sub, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_count
  );
endinterface

// File: rtl/signed_acc_stage.sv
// Multi-operand signed add/sub accumulator with a sticky overflow flag and a saturating count.
// Optional feature: define ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module signed_acc_stage #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  signed_acc_stage_if.slave      bus,
  output logic [0:0]             o_dbg_state
);
  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;
  logic [7:0]       r_cnt;

  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_raw;
  logic             w_step_ovf;
  logic [WIDTH-1:0] w_next;

  // Ripple add/sub: subtraction is acc + ~data + 1, the +1 entering as the initial carry.
  always_comb begin
    w_b        = bus.in_sub ? ~bus.in_data : bus.in_data;
    w_carry    = '0;
    w_carry[0] = bus.in_sub;
    w_raw      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_raw[i]     = r_acc[i] ^ w_b[i] ^ w_carry[i];
      w_carry[i+1] = (r_acc[i] & w_b[i]) | (r_acc[i] & w_carry[i]) | (w_b[i] & w_carry[i]);
    end
    w_step_ovf = w_carry[WIDTH-1] ^ w_carry[WIDTH];
`ifdef ACC_SATURATE_EN
    // On overflow both effective operand signs agree, so the accumulator sign picks the rail.
    if (w_step_ovf) begin
      w_next = r_acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_next = w_raw;
    end
`else
    w_next = w_raw;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (bus.in_valid) begin
            r_acc <= w_next;
            r_ovf <= r_ovf | w_step_ovf;
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            if (bus.in_last) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_ACCUM;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  // Handshake outputs come from the state register alone.
  assign bus.in_ready  = (r_state == ST_ACCUM);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_sum   = r_acc;
  assign bus.out_ovf   = r_ovf;
  assign bus.out_count = r_cnt;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_signed_acc_stage.sv
// Directed-vector bench for signed_acc_stage; expectations are hand-computed per scenario.
module tb_signed_acc_stage;
  logic       clk;
  logic       rst_n;
  logic [0:0] dbg_state;
  int         n_checks;
  int         n_errors;

  signed_acc_stage_if #(.WIDTH(8)) bus ();

  signed_acc_stage #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic send(input logic [7:0] data, input logic sub, input logic last);
    int budget;
    budget = 20;
    while (bus.in_ready !== 1'b1 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL send_ready: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_sub   = sub;
    bus.in_last  = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_sub   = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  // Called #1 after the in_last accept edge: checks result, handshakes, checks cleared state.
  task automatic collect(input string name, input logic [7:0] exp_sum, input logic exp_ovf,
                         input logic [7:0] exp_cnt);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_valid: out_valid=%b in_ready=%b required 1/0", name, bus.out_valid, bus.in_ready);
    end
    n_checks++;
    if (bus.out_sum !== exp_sum) begin
      n_errors++;
      $display("FAIL %s_sum: got %h required %h", name, bus.out_sum, exp_sum);
    end
    n_checks++;
    if (bus.out_ovf !== exp_ovf) begin
      n_errors++;
      $display("FAIL %s_ovf: got %b required %b", name, bus.out_ovf, exp_ovf);
    end
    n_checks++;
    if (bus.out_count !== exp_cnt) begin
      n_errors++;
      $display("FAIL %s_count: got %0d required %0d", name, bus.out_count, exp_cnt);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sum !== 8'h00 ||
        bus.out_ovf !== 1'b0 || bus.out_count !== 8'h00) begin
      n_errors++;
      $display("FAIL %s_clear: rdy=%b vld=%b sum=%h ovf=%b cnt=%0d required 1/0/00/0/0",
               name, bus.in_ready, bus.out_valid, bus.out_sum, bus.out_ovf, bus.out_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sum !== 8'h00 ||
        bus.out_ovf !== 1'b0 || bus.out_count !== 8'h00 || dbg_state !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: rdy=%b vld=%b sum=%h ovf=%b cnt=%0d st=%b",
               bus.in_ready, bus.out_valid, bus.out_sum, bus.out_ovf, bus.out_count, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    send(8'd5, 1'b0, 1'b0);
    send(8'd7, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== 8'h0C) begin
      n_errors++;
      $display("FAIL addsub_mid: out_valid=%b sum=%h required 0/0c", bus.out_valid, bus.out_sum);
    end
    send(8'd2, 1'b1, 1'b1);
    collect("addsub", 8'h0A, 1'b0, 8'd3);
  endtask

  task automatic test_overflow();
`ifdef ACC_SATURATE_EN
    send(8'd100, 1'b0, 1'b0); send(8'd100, 1'b0, 1'b1);
    collect("pos_ovf", 8'h7F, 1'b1, 8'd2);
    send(8'h80, 1'b1, 1'b1);
    collect("neg_bound", 8'h7F, 1'b1, 8'd1);
    send(8'd127, 1'b0, 1'b0); send(8'hFF, 1'b1, 1'b1);
    collect("max_minus_m1", 8'h7F, 1'b1, 8'd2);
    send(8'd100, 1'b0, 1'b0); send(8'd100, 1'b0, 1'b0); send(8'd100, 1'b1, 1'b1);
    collect("sticky", 8'h1B, 1'b1, 8'd3);
`else
    send(8'd100, 1'b0, 1'b0); send(8'd100, 1'b0, 1'b1);
    collect("pos_ovf", 8'hC8, 1'b1, 8'd2);
    send(8'h80, 1'b1, 1'b1);
    collect("neg_bound", 8'h80, 1'b1, 8'd1);
    send(8'd127, 1'b0, 1'b0); send(8'hFF, 1'b1, 1'b1);
    collect("max_minus_m1", 8'h80, 1'b1, 8'd2);
    send(8'd100, 1'b0, 1'b0); send(8'd100, 1'b0, 1'b0); send(8'd100, 1'b1, 1'b1);
    collect("sticky", 8'h64, 1'b1, 8'd3);
`endif
    // -100 + -28 = -128 exactly: no overflow
    send(8'h9C, 1'b0, 1'b0); send(8'd28, 1'b1, 1'b1);
    collect("neg_edge", 8'h80, 1'b0, 8'd2);
  endtask

  task automatic test_backpressure();
    send(8'd20, 1'b0, 1'b0);
    send(8'd3, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = 8'd55;
      bus.in_last  = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== 8'h11 ||
          bus.out_ovf !== 1'b0 || bus.out_count !== 8'd2) begin
        n_errors++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b sum=%h ovf=%b cnt=%0d required 1/0/11/0/2",
                 i, bus.out_valid, bus.in_ready, bus.out_sum, bus.out_ovf, bus.out_count);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
    collect("bp", 8'h11, 1'b0, 8'd2);
  endtask

  task automatic test_reset_mid();
    send(8'd3, 1'b0, 1'b0);
    send(8'd4, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sum !== 8'h00 ||
        bus.out_ovf !== 1'b0 || bus.out_count !== 8'h00) begin
      n_errors++;
      $display("FAIL rst_mid: rdy=%b vld=%b sum=%h ovf=%b cnt=%0d required 1/0/00/0/0",
               bus.in_ready, bus.out_valid, bus.out_sum, bus.out_ovf, bus.out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'd9, 1'b0, 1'b1);
    collect("after_rst", 8'h09, 1'b0, 8'd1);
  endtask

  task automatic test_count_saturate();
    for (int i = 0; i < 259; i++) send(8'h00, 1'b0, 1'b0);
    send(8'd1, 1'b0, 1'b1);
    collect("cnt_sat", 8'h01, 1'b0, 8'd255);
  endtask

  task automatic test_back_to_back();
    send(8'hF0, 1'b0, 1'b0);
    send(8'h05, 1'b0, 1'b1);
    collect("b2b_a", 8'hF5, 1'b0, 8'd2);
    send(8'h01, 1'b1, 1'b1);
    collect("b2b_b", 8'hFF, 1'b0, 8'd1);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_sub    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add_sub();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_count_saturate();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
